// File: rtl/sprite_physics_engine.sv
// sprite_physics_engine: per-frame fixed-point sprite motion (walk/fall/climb/stun), platform snap, X clamp.
// Latency: state/speed/position update only on the startOfFrame cycle and are visible the next cycle; no backpressure.
// Build option SPRITE_STUN_EN adds the electrified-rope hazard latch and STUN countdown.
module sprite_physics_engine #(
    parameter int N_ROPES      = 6,
    parameter int FRAC_BITS    = 6,
    parameter int INITIAL_X    = 280,
    parameter int INITIAL_Y    = 185,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 570,
    parameter int N_LEVELS     = 3,
    parameter int LEVEL_BASE_Y = 388,
    parameter int LEVEL_PITCH  = 129,
    parameter int SNAP_WIN     = 3,
    parameter int GRAVITY      = 10,
    parameter int MAX_FALL     = 230,
    parameter int JUMP_SPEED   = 300,
    parameter int CLIMB_SPEED  = 100,
    parameter int WALK_SPEED   = 150,
    parameter int STUN_FRAMES  = 150
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    leftPressed,
    input  logic                    rightPressed,
    input  logic                    upPressed,
    input  logic                    downPressed,
    input  logic                    onRope,
    input  logic                    onBlock,
    input  logic [N_ROPES-1:0]      ropeCollisions,
    input  logic [N_ROPES-1:0][1:0] electroStatus,
    input  logic signed [31:0]      addedSpeed,
    output logic signed [10:0]      topLeftX,
    output logic signed [10:0]      topLeftY,
    output logic [1:0]              state,
    output logic                    stunned
);
    typedef enum logic [1:0] {
        WALK  = 2'd0,
        FALL  = 2'd1,
        CLIMB = 2'd2,
        STUN  = 2'd3
    } state_t;

    localparam int ONE_FP = 2 ** FRAC_BITS;
    localparam logic signed [31:0] X_INIT_FP = INITIAL_X * ONE_FP;
    localparam logic signed [31:0] Y_INIT_FP = INITIAL_Y * ONE_FP;

    state_t             state_q, state_d;
    logic signed [31:0] x_pos, x_pos_d;
    logic signed [31:0] y_pos, y_pos_d;
    logic signed [31:0] y_spd, y_spd_d;
    logic signed [31:0] x_spd, x_try, y_sum, y_grav, lvl_pos;
    int                 y_pix, x_pix_try;
    logic               near_lvl, snap;
    logic               hazard_go;
    logic               stun_done;

`ifdef SPRITE_STUN_EN
    localparam int CW = $clog2(STUN_FRAMES + 1);

    logic [CW-1:0] stun_cnt, stun_cnt_d;
    logic          hz_latch, hz_latch_d, hz_now;

    always_comb begin
        hz_now = 1'b0;
        for (int i = 0; i < N_ROPES; i++) begin
            if (ropeCollisions[i] && electroStatus[i] == 2'b10) hz_now = 1'b1;
        end
    end

    assign hazard_go = hz_latch && (state_q != STUN);
    assign stun_done = (stun_cnt <= CW'(1));
    assign stunned   = (state_q == STUN);

    // Hazards seen while already stunned are dropped, never queued for later.
    always_comb begin
        stun_cnt_d = stun_cnt;
        hz_latch_d = hz_latch;
        if (state_q != STUN && hz_now) hz_latch_d = 1'b1;
        if (startOfFrame) begin
            if (hazard_go) begin
                stun_cnt_d = CW'(STUN_FRAMES);
                hz_latch_d = 1'b0;
            end else if (state_q == STUN) begin
                stun_cnt_d = stun_done ? '0 : stun_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stun_cnt <= '0;
            hz_latch <= 1'b0;
        end else begin
            stun_cnt <= stun_cnt_d;
            hz_latch <= hz_latch_d;
        end
    end
`else
    logic unused_hazard_inputs;

    assign unused_hazard_inputs = ^{ropeCollisions, electroStatus};
    assign hazard_go            = 1'b0;
    assign stun_done            = 1'b1;
    assign stunned              = 1'b0;
`endif

    // Snap target is judged on the current pixel Y, before this frame's motion.
    always_comb begin
        y_pix    = int'(y_pos >>> FRAC_BITS);
        near_lvl = 1'b0;
        lvl_pos  = '0;
        for (int k = N_LEVELS - 1; k >= 0; k--) begin
            if (y_pix - (LEVEL_BASE_Y - k * LEVEL_PITCH) <= SNAP_WIN &&
                (LEVEL_BASE_Y - k * LEVEL_PITCH) - y_pix <= SNAP_WIN) begin
                near_lvl = 1'b1;
                lvl_pos  = (LEVEL_BASE_Y - k * LEVEL_PITCH) * ONE_FP;
            end
        end
    end

    always_comb begin
        x_spd = addedSpeed;
        if (rightPressed && !leftPressed)      x_spd = addedSpeed + WALK_SPEED;
        else if (leftPressed && !rightPressed) x_spd = addedSpeed - WALK_SPEED;
        x_try     = x_pos + x_spd;
        x_pix_try = int'(x_try >>> FRAC_BITS);
        y_sum     = y_spd + GRAVITY;
        y_grav    = (y_sum > MAX_FALL) ? MAX_FALL : y_sum;
    end

    always_comb begin
        state_d = state_q;
        x_pos_d = x_pos;
        y_pos_d = y_pos;
        y_spd_d = y_spd;
        snap    = 1'b0;
        if (startOfFrame) begin
            if (hazard_go) begin
                state_d = STUN;
                y_spd_d = '0;
            end else begin
                case (state_q)
                    WALK: begin
                        y_spd_d = '0;
                        if (onRope && (upPressed || downPressed)) begin
                            state_d = CLIMB;
                        end else if (upPressed) begin
                            state_d = FALL;
                            y_spd_d = -JUMP_SPEED;
                        end else if (!onBlock) begin
                            state_d = FALL;
                        end
                    end
                    FALL: begin
                        if (y_spd >= 0 && onRope) begin
                            state_d = CLIMB;
                            y_spd_d = '0;
                        end else if (y_spd >= 0 && onBlock && near_lvl) begin
                            state_d = WALK;
                            y_spd_d = '0;
                            snap    = 1'b1;
                        end else begin
                            y_spd_d = y_grav;
                        end
                    end
                    CLIMB: begin
                        y_spd_d = '0;
                        if (!onRope)                          state_d = FALL;
                        else if (upPressed && !downPressed)   y_spd_d = -CLIMB_SPEED;
                        else if (downPressed && !upPressed)   y_spd_d = CLIMB_SPEED;
                    end
                    default: begin
                        if (stun_done) begin
                            state_d = FALL;
                            y_spd_d = '0;
                        end
                    end
                endcase
                if (state_q != STUN) begin
                    if (x_pix_try > X_MAX)      x_pos_d = X_MAX * ONE_FP;
                    else if (x_pix_try < X_MIN) x_pos_d = X_MIN * ONE_FP;
                    else                        x_pos_d = x_try;
                end
            end
            y_pos_d = snap ? lvl_pos : y_pos + y_spd_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FALL;
            x_pos   <= X_INIT_FP;
            y_pos   <= Y_INIT_FP;
            y_spd   <= '0;
        end else begin
            state_q <= state_d;
            x_pos   <= x_pos_d;
            y_pos   <= y_pos_d;
            y_spd   <= y_spd_d;
        end
    end

    assign topLeftX = x_pos[FRAC_BITS +: 11];
    assign topLeftY = y_pos[FRAC_BITS +: 11];
    assign state    = state_q;

endmodule

// File: tb/tb_sprite_physics_engine.sv
// Bench for sprite_physics_engine: frame-level behavioural model, per-cycle compare, directed + random frames.
module tb_sprite_physics_engine;
    localparam int NR           = 6;
    localparam int FB           = 6;
    localparam int ONE          = 64;
    localparam int X_MIN        = 0;
    localparam int X_MAX        = 570;
    localparam int N_LEVELS     = 3;
    localparam int LEVEL_BASE_Y = 388;
    localparam int LEVEL_PITCH  = 129;
    localparam int SNAP_WIN     = 3;
    localparam int GRAVITY      = 10;
    localparam int MAX_FALL     = 230;
    localparam int JUMP_SPEED   = 300;
    localparam int CLIMB_SPEED  = 100;
    localparam int WALK_SPEED   = 150;
    localparam int STUN_FRAMES  = 150;
    localparam int ST_WALK = 0, ST_FALL = 1, ST_CLIMB = 2, ST_STUN = 3;
`ifdef SPRITE_STUN_EN
    localparam bit STUN_EN = 1'b1;
`else
    localparam bit STUN_EN = 1'b0;
`endif

    logic clk;
    logic reset, startOfFrame;
    logic leftPressed, rightPressed, upPressed, downPressed, onRope, onBlock;
    logic [NR-1:0]      ropeCollisions;
    logic [NR-1:0][1:0] electroStatus;
    logic signed [31:0] addedSpeed;
    logic signed [10:0] topLeftX, topLeftY;
    logic [1:0]         state;
    logic               stunned;

    int checks = 0;
    int errors = 0;
    int m_state, m_x, m_y, m_ys, m_cnt;
    bit m_latch, m_go, m_hz;

    sprite_physics_engine dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .leftPressed(leftPressed), .rightPressed(rightPressed),
        .upPressed(upPressed), .downPressed(downPressed),
        .onRope(onRope), .onBlock(onBlock),
        .ropeCollisions(ropeCollisions), .electroStatus(electroStatus),
        .addedSpeed(addedSpeed),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .state(state), .stunned(stunned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int px(input int v);
        logic signed [10:0] t;
        t = 11'(v >>> FB);
        return int'(t);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One frame of the game rules, applied to the model's pixel-scaled integers.
    task automatic model_frame(input bit go);
        int xs, nx, py, lvl, d;
        bit near;
        if (go) begin
            m_state = ST_STUN; m_cnt = STUN_FRAMES; m_ys = 0;
            return;
        end
        if (m_state == ST_STUN) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin m_state = ST_FALL; m_ys = 0; end
            return;
        end
        xs = int'(addedSpeed) + WALK_SPEED * (int'(rightPressed) - int'(leftPressed));
        nx = m_x + xs;
        if ((nx >>> FB) > X_MAX)      m_x = X_MAX * ONE;
        else if ((nx >>> FB) < X_MIN) m_x = X_MIN * ONE;
        else                          m_x = nx;
        py = m_y >>> FB;
        near = 1'b0; lvl = 0;
        for (int k = 0; k < N_LEVELS; k++) begin
            d = py - (LEVEL_BASE_Y - k * LEVEL_PITCH);
            if (!near && (d < 0 ? -d : d) <= SNAP_WIN) begin
                near = 1'b1; lvl = LEVEL_BASE_Y - k * LEVEL_PITCH;
            end
        end
        case (m_state)
            ST_WALK: begin
                if (onRope && (upPressed || downPressed)) begin m_state = ST_CLIMB; m_ys = 0; end
                else if (upPressed)                       begin m_state = ST_FALL; m_ys = -JUMP_SPEED; end
                else if (!onBlock)                        begin m_state = ST_FALL; m_ys = 0; end
                else m_ys = 0;
                m_y = m_y + m_ys;
            end
            ST_FALL: begin
                if (m_ys >= 0 && onRope) begin
                    m_state = ST_CLIMB; m_ys = 0;
                end else if (m_ys >= 0 && onBlock && near) begin
                    m_state = ST_WALK; m_ys = 0; m_y = lvl * ONE;
                end else begin
                    m_ys = (m_ys + GRAVITY > MAX_FALL) ? MAX_FALL : m_ys + GRAVITY;
                    m_y  = m_y + m_ys;
                end
            end
            default: begin
                if (!onRope) begin m_state = ST_FALL; m_ys = 0; end
                else m_ys = CLIMB_SPEED * (int'(downPressed) - int'(upPressed));
                m_y = m_y + m_ys;
            end
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = ST_FALL; m_x = 280 * ONE; m_y = 185 * ONE;
            m_ys = 0; m_cnt = 0; m_latch = 1'b0;
        end else begin
            m_hz = 1'b0;
            for (int i = 0; i < NR; i++)
                if (ropeCollisions[i] && electroStatus[i] == 2'b10) m_hz = 1'b1;
            m_go = STUN_EN && m_latch && m_state != ST_STUN;
            if (STUN_EN && m_hz && m_state != ST_STUN) m_latch = 1'b1;
            if (startOfFrame) begin
                if (m_go) m_latch = 1'b0;
                model_frame(m_go);
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (reset === 1'b0) begin
            check("cyc_x", int'(topLeftX), px(m_x));
            check("cyc_y", int'(topLeftY), px(m_y));
            check("cyc_state", int'(state), m_state);
            check("cyc_stunned", int'(stunned), int'(m_state == ST_STUN));
        end
    end

    task automatic tick();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input logic [NR-1:0] rc, input logic [NR-1:0][1:0] es);
        ropeCollisions = rc;
        electroStatus  = es;
        @(negedge clk);
        ropeCollisions = '0;
        electroStatus  = '0;
    endtask

    int n, prev;
    logic [31:0] r;
    logic [NR-1:0] rc;
    logic [NR-1:0][1:0] es;

    initial begin
        reset = 1'b1; startOfFrame = 1'b0;
        leftPressed = 1'b0; rightPressed = 1'b0; upPressed = 1'b0; downPressed = 1'b0;
        onRope = 1'b0; onBlock = 1'b0; ropeCollisions = '0; electroStatus = '0; addedSpeed = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_x", int'(topLeftX), 280);
        check("rst_y", int'(topLeftY), 185);
        check("rst_state", int'(state), ST_FALL);
        check("rst_stunned", int'(stunned), 0);

        // Free fall from spawn: speeds 10..50, 150 units below 185*64
        prev = int'(topLeftY);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fall_mono", int'(int'(topLeftY) >= prev), 1);
            prev = int'(topLeftY);
        end
        check("fall_yspd_model", m_ys, 50);
        check("fall_y", int'(topLeftY), 187);

        n = 0;
        while (px(m_y) < 385 && n < 300) begin tick(); n++; end
        check("fall_reach_window", int'(n < 300), 1);
        onBlock = 1'b1;
        tick();
        check("snap_state", int'(state), ST_WALK);
        check("snap_y", int'(topLeftY), 388);

        leftPressed = 1'b1; rightPressed = 1'b1;
        repeat (10) tick();
        check("both_keys_x", int'(topLeftX), 280);
        check("both_keys_state", int'(state), ST_WALK);
        leftPressed = 1'b0; rightPressed = 1'b0;

        upPressed = 1'b1;
        tick();
        upPressed = 1'b0;
        check("jump_state", int'(state), ST_FALL);
        check("jump_ys_model", m_ys, -JUMP_SPEED);
        check("jump_y", int'(topLeftY), 383);
        n = 0;
        while (state != 2'd0 && n < 150) begin tick(); n++; end
        check("jump_land", int'(n < 150), 1);
        check("jump_land_y", int'(topLeftY), 388);

        rightPressed = 1'b1;
        n = 0;
        while (px(m_x) < 565 && n < 300) begin tick(); n++; end
        repeat (5) tick();
        check("clamp_right", int'(topLeftX), 570);
        tick();
        check("clamp_right_hold", int'(topLeftX), 570);
        rightPressed = 1'b0;
        leftPressed = 1'b1; addedSpeed = -32'sd4000;
        repeat (12) tick();
        check("clamp_left", int'(topLeftX), 0);
        leftPressed = 1'b0; addedSpeed = '0;

        // Collision on one rope with another rope live, then a dead-status collision
        rc = '0; rc[2] = 1'b1; es = '0; es[3] = 2'b10;
        pulse(rc, es);
        tick();
        check("hz_mismatch_state", int'(state), ST_WALK);
        rc = '0; rc[3] = 1'b1; es = '0; es[3] = 2'b01;
        pulse(rc, es);
        tick();
        check("hz_dead_state", int'(state), ST_WALK);

        rc = '0; rc[3] = 1'b1; es = '0; es[3] = 2'b10;
        pulse(rc, es);
        tick();
`ifdef SPRITE_STUN_EN
        check("stun_enter", int'(state), ST_STUN);
        check("stun_flag", int'(stunned), 1);
        rightPressed = 1'b1;
        repeat (49) tick();
        pulse(rc, es);
        repeat (100) tick();
        check("stun_hold_state", int'(state), ST_STUN);
        check("stun_hold_x", int'(topLeftX), 0);
        check("stun_hold_y", int'(topLeftY), 388);
        tick();
        check("stun_exit_state", int'(state), ST_FALL);
        check("stun_exit_x", int'(topLeftX), 0);
        rightPressed = 1'b0;
        tick();
        check("stun_no_retrigger", int'(state), ST_WALK);
`else
        check("nostun_state", int'(state), ST_WALK);
        check("nostun_flag", int'(stunned), 0);
`endif

        upPressed = 1'b1;
        tick();
        upPressed = 1'b0;
        check("midjump_state", int'(state), ST_FALL);
        reset = 1'b1;
        #1;
        check("rst_async_x", int'(topLeftX), 280);
        check("rst_async_y", int'(topLeftY), 185);
        check("rst_async_state", int'(state), ST_FALL);
        @(negedge clk);
        reset = 1'b0; onBlock = 1'b0;
        tick();
        check("post_rst_state", int'(state), ST_FALL);
        check("post_rst_y", int'(topLeftY), 185);
        check("post_rst_ys_model", m_ys, GRAVITY);

`ifdef SPRITE_STUN_EN
        pulse(rc, es);
        tick();
        check("stun2_enter", int'(state), ST_STUN);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("midstun_rst_state", int'(state), ST_FALL);
        check("midstun_rst_flag", int'(stunned), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("midstun_post_state", int'(state), ST_FALL);
`endif

        for (int f = 0; f < 600; f++) begin
            r = $urandom;
            leftPressed  = r[0];
            rightPressed = r[1];
            upPressed    = (r[4:2] == 3'd0);
            downPressed  = r[5] & r[6];
            onRope       = (r[9:7] == 3'd0);
            onBlock      = (r[11:10] != 2'd0);
            addedSpeed   = 32'($urandom_range(0, 400)) - 32'd200;
            if (r[15:12] == 4'd0) begin
                ropeCollisions = NR'($urandom);
                electroStatus  = (2 * NR)'($urandom);
            end else begin
                ropeCollisions = '0;
                electroStatus  = '0;
            end
            if (r[21:16] == 6'd0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
